// File: rtl/pipe_pkg.sv
// Shared pipeline field widths and EX/MEM packing layout for the 32-bit MIPS core.
// Control sits at the LSBs so a bubble can zero it with a low-bit mask.
package pipe_pkg;
  localparam int WB_W       = 2;
  localparam int MEM_W      = 3;
  localparam int CTRL_W     = WB_W + MEM_W;
  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;
  localparam int EXMEM_W    = 107;

  localparam int EXMEM_CTRL_LSB = 0;
  localparam int EXMEM_DST_LSB  = EXMEM_CTRL_LSB + CTRL_W;
  localparam int EXMEM_ZERO_LSB = EXMEM_DST_LSB + REG_ADDR_W;
  localparam int EXMEM_RD2_LSB  = EXMEM_ZERO_LSB + 1;
  localparam int EXMEM_ALU_LSB  = EXMEM_RD2_LSB + XLEN;
  localparam int EXMEM_PC4_LSB  = EXMEM_ALU_LSB + XLEN;

  // Declared MSB first, so ctrl lands at bit 0.
  typedef struct packed {
    logic [XLEN-1:0]       pc4;
    logic [XLEN-1:0]       alu;
    logic [XLEN-1:0]       rd2;
    logic                  zero;
    logic [REG_ADDR_W-1:0] dst;
    logic [CTRL_W-1:0]     ctrl;
  } exmem_t;
endpackage

// File: rtl/pipe_stage_reg_if.sv
// Upstream/downstream handshake bundle of one pipeline stage.
// slave = the stage register, master = whatever drives and consumes it.
interface pipe_stage_reg_if #(
  parameter int DATA_W = 107,
  parameter int CNT_W  = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CNT_W-1:0]  stall_cnt;

  modport master (
    output in_valid, in_data, flush, out_ready,
    input  in_ready, out_valid, out_data, stall_cnt
  );

  modport slave (
    input  in_valid, in_data, flush, out_ready,
    output in_ready, out_valid, out_data, stall_cnt
  );
endinterface

// File: rtl/pipe_skid_slot.sv
// One valid+data holding register; kill beats load, load beats drain.
// Data is only written on a surviving load so the payload holds through bubbles.
module pipe_skid_slot #(
  parameter int DATA_W = 107
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              kill_i,
  input  logic              load_i,
  input  logic              drain_i,
  input  logic [DATA_W-1:0] dat_i,
  output logic              vld_o,
  output logic [DATA_W-1:0] dat_o
);
  logic              vld_q, vld_d;
  logic [DATA_W-1:0] dat_q, dat_d;

  always_comb begin
    vld_d = vld_q;
    dat_d = dat_q;
    if (kill_i) begin
      vld_d = 1'b0;
    end else if (load_i) begin
      vld_d = 1'b1;
      dat_d = dat_i;
    end else if (drain_i) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      vld_q <= 1'b0;
      dat_q <= '0;
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
    end
  end

  assign vld_o = vld_q;
  assign dat_o = dat_q;
endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline stage: valid/ready, flush, bubble NOP on control bits, optional skid slot.
// Adds one cycle of latency; with SKID=1 in_ready comes straight from the skid valid flop.
module pipe_stage_reg #(
  parameter int DATA_W = pipe_pkg::EXMEM_W,
  parameter int CTRL_W = pipe_pkg::CTRL_W,
  parameter int SKID   = 0,
  parameter int CNT_W  = 16
) (
  input  logic             clock,
  input  logic             reset,
  pipe_stage_reg_if.slave  bus
);
  localparam logic [DATA_W-1:0] CTRL_MASK = (DATA_W'(1) << CTRL_W) - DATA_W'(1);

  logic              main_vld, skid_vld;
  logic [DATA_W-1:0] main_dat, skid_dat, main_src;
  logic              in_xfer, main_load;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  assign bus.in_ready = (SKID != 0) ? !skid_vld : (!main_vld || bus.out_ready);
  assign in_xfer      = bus.in_valid && bus.in_ready;

  // A parked skid beat always goes to main before anything new.
  assign main_load = (skid_vld && bus.out_ready) ||
                     (in_xfer && !skid_vld && (!main_vld || bus.out_ready));
  assign main_src  = skid_vld ? skid_dat : bus.in_data;

  pipe_skid_slot #(.DATA_W(DATA_W)) u_main (
    .clock   (clock),
    .reset   (reset),
    .kill_i  (bus.flush),
    .load_i  (main_load),
    .drain_i (bus.out_ready),
    .dat_i   (main_src),
    .vld_o   (main_vld),
    .dat_o   (main_dat)
  );

  if (SKID != 0) begin : g_skid
    logic skid_load;
    assign skid_load = in_xfer && main_vld && !bus.out_ready;

    pipe_skid_slot #(.DATA_W(DATA_W)) u_skid (
      .clock   (clock),
      .reset   (reset),
      .kill_i  (bus.flush),
      .load_i  (skid_load),
      .drain_i (bus.out_ready),
      .dat_i   (bus.in_data),
      .vld_o   (skid_vld),
      .dat_o   (skid_dat)
    );
  end else begin : g_noskid
    assign skid_vld = 1'b0;
    assign skid_dat = '0;
  end

  assign bus.out_valid = main_vld;
  assign bus.out_data  = main_vld ? main_dat : (main_dat & ~CTRL_MASK);

  always_comb begin
    cnt_d = cnt_q;
    if (main_vld && !bus.out_ready && (cnt_q != {CNT_W{1'b1}}))
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign bus.stall_cnt = cnt_q;
endmodule

// File: tb/tb_pipe_stage_reg.sv
// Drives a SKID=0 (4-bit counter) and a SKID=1 stage with shared stimulus;
// per-DUT scoreboards track held beats and stall counts.
module tb_pipe_stage_reg;
  import pipe_pkg::*;

  localparam int DW = 107;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid, flush, out_ready;
  logic [DW-1:0] in_data;
  int            n_chk  = 0;
  int            n_pass = 0;

  always #5 clk = ~clk;

  pipe_stage_reg_if #(.DATA_W(DW), .CNT_W(4))  bus0 ();
  pipe_stage_reg_if #(.DATA_W(DW), .CNT_W(16)) bus1 ();

  assign bus0.in_valid  = in_valid;
  assign bus0.in_data   = in_data;
  assign bus0.flush     = flush;
  assign bus0.out_ready = out_ready;
  assign bus1.in_valid  = in_valid;
  assign bus1.in_data   = in_data;
  assign bus1.flush     = flush;
  assign bus1.out_ready = out_ready;

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(5), .SKID(0), .CNT_W(4)) dut0 (
    .clock(clk), .reset(reset), .bus(bus0)
  );
  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(5), .SKID(1), .CNT_W(16)) dut1 (
    .clock(clk), .reset(reset), .bus(bus1)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];
  int            cnt0, cnt1;

  // Scoreboards evaluated at negedge on the values the next posedge will act on.
  always @(negedge clk) begin
    if (reset) begin
      q0.delete();
      cnt0 = 0;
    end else begin
      chk("vld0", 128'(bus0.out_valid), 128'(q0.size() != 0));
      chk("rdy0", 128'(bus0.in_ready), 128'((q0.size() == 0) || out_ready));
      chk("cnt0", 128'(bus0.stall_cnt), 128'(cnt0));
      if (!bus0.out_valid) chk("bub0", 128'(bus0.out_data[4:0]), 128'(0));
      if (bus0.out_valid && out_ready) begin
        if (q0.size() != 0) chk("dat0", 128'(bus0.out_data), 128'(q0.pop_front()));
        else                chk("unexp0", 128'(1), 128'(0));
      end
      if (flush) q0.delete();
      else if (in_valid && bus0.in_ready) q0.push_back(in_data);
      if (bus0.out_valid && !out_ready && cnt0 != 15) cnt0++;
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      q1.delete();
      cnt1 = 0;
    end else begin
      chk("vld1", 128'(bus1.out_valid), 128'(q1.size() != 0));
      chk("rdy1", 128'(bus1.in_ready), 128'(q1.size() < 2));
      chk("cnt1", 128'(bus1.stall_cnt), 128'(cnt1));
      if (!bus1.out_valid) chk("bub1", 128'(bus1.out_data[4:0]), 128'(0));
      if (bus1.out_valid && out_ready) begin
        if (q1.size() != 0) chk("dat1", 128'(bus1.out_data), 128'(q1.pop_front()));
        else                chk("unexp1", 128'(1), 128'(0));
      end
      if (flush) q1.delete();
      else if (in_valid && bus1.in_ready) q1.push_back(in_data);
      if (bus1.out_valid && !out_ready) cnt1++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    exmem_t        pkt;
    logic [DW-1:0] pat;
    int            base1;

    reset     = 1'b1;
    in_valid  = 1'b1;
    flush     = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < DW; i++) in_data[i] = (i % 8 == 1) || (i % 8 == 3) || (i % 8 == 4) || (i % 8 == 6);
    step();
    step();
    chk("rst_vld0", 128'(bus0.out_valid), 128'(0));
    chk("rst_vld1", 128'(bus1.out_valid), 128'(0));
    chk("rst_dat0", 128'(bus0.out_data), 128'(0));
    chk("rst_dat1", 128'(bus1.out_data), 128'(0));
    chk("rst_cnt0", 128'(bus0.stall_cnt), 128'(0));
    chk("rst_cnt1", 128'(bus1.stall_cnt), 128'(0));
    reset    = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("rst_rdy0", 128'(bus0.in_ready), 128'(1));
    chk("rst_rdy1", 128'(bus1.in_ready), 128'(1));
    step();

    // Streaming at full rate.
    out_ready = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      in_valid = 1'b1;
      in_data  = DW'(i);
      step();
      chk("stream_vld0", 128'(bus0.out_valid), 128'(1));
      chk("stream_dat1", 128'(bus1.out_data), 128'(i));
    end
    in_valid = 1'b0;
    step();
    step();

    // Backpressure: A, B, C with downstream stalled.
    base1     = int'(bus1.stall_cnt);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = DW'(32'hA0A);
    step();
    in_data = DW'(32'hB0B);
    step();
    in_data = DW'(32'hC0C);
    chk("bp_rdy1_a", 128'(bus1.in_ready), 128'(0));
    chk("bp_main1", 128'(bus1.out_data), 128'(32'hA0A));
    step();
    chk("bp_rdy1_b", 128'(bus1.in_ready), 128'(0));
    chk("bp_cnt1", 128'(bus1.stall_cnt), 128'(base1 + 2));
    out_ready = 1'b1;
    step();
    chk("bp_out_b", 128'(bus1.out_data), 128'(32'hB0B));
    step();
    in_valid = 1'b0;
    chk("bp_out_c", 128'(bus1.out_data), 128'(32'hC0C));
    step();
    chk("bp_empty1", 128'(bus1.out_valid), 128'(0));
    chk("bp_cnt1_hold", 128'(bus1.stall_cnt), 128'(base1 + 2));

    // Flush with two beats held and a new beat D offered.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = DW'(32'hE1F);
    step();
    in_data = DW'(32'hF1F);
    step();
    flush   = 1'b1;
    in_data = DW'(32'hD1F);
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("fl_vld1", 128'(bus1.out_valid), 128'(0));
    chk("fl_ctrl1", 128'(bus1.out_data[4:0]), 128'(0));
    chk("fl_vld0", 128'(bus0.out_valid), 128'(0));
    out_ready = 1'b1;
    step();
    step();

    // Bubble masking keeps non-control bits.
    pkt      = '0;
    pkt.pc4  = 32'h0040_0004;
    pkt.alu  = 32'hDEAD_BEEF;
    pkt.rd2  = 32'h1234_5678;
    pkt.zero = 1'b1;
    pkt.dst  = 5'd9;
    pkt.ctrl = 5'b10111;
    pat      = pkt;
    in_valid = 1'b1;
    in_data  = pat;
    step();
    in_valid = 1'b0;
    chk("bub_live1", 128'(bus1.out_data[4:0]), 128'(5'b10111));
    step();
    chk("bub_vld0", 128'(bus0.out_valid), 128'(0));
    chk("bub_ctrl0", 128'(bus0.out_data[4:0]), 128'(0));
    chk("bub_hi0", 128'(bus0.out_data[DW-1:5]), 128'(pat[DW-1:5]));
    chk("bub_hi1", 128'(bus1.out_data[DW-1:5]), 128'(pat[DW-1:5]));

    // Mid-stream reset with a beat held.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = DW'(32'h77);
    step();
    in_valid = 1'b0;
    reset    = 1'b1;
    step();
    reset = 1'b0;
    chk("mr_vld0", 128'(bus0.out_valid), 128'(0));
    chk("mr_vld1", 128'(bus1.out_valid), 128'(0));
    chk("mr_dat1", 128'(bus1.out_data), 128'(0));
    chk("mr_cnt0", 128'(bus0.stall_cnt), 128'(0));

    // Saturation: 20 stalled cycles.
    in_valid = 1'b1;
    in_data  = DW'(32'h99);
    step();
    in_valid = 1'b0;
    repeat (20) step();
    chk("sat_cnt0", 128'(bus0.stall_cnt), 128'(15));
    chk("sat_cnt1", 128'(bus1.stall_cnt), 128'(20));
    repeat (3) step();
    chk("sat_hold0", 128'(bus0.stall_cnt), 128'(15));
    out_ready = 1'b1;
    step();
    step();
    chk("end_q0", 128'(q0.size()), 128'(0));
    chk("end_q1", 128'(q1.size()), 128'(0));
    chk("end_vld1", 128'(bus1.out_valid), 128'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised elastic pipeline-stage register that replaces the fixed-width per-stage latches (ID/EX, EX/MEM, MEM/WB) of the 32-bit MIPS core with one reusable block. It carries an arbitrary payload with a valid/ready handshake, synchronous flush, and bubble insertion that zeroes the control field. An optional skid slot registers the upstream ready path. A saturating stall counter supports performance debug.

## Interface

Parameters:
- DATA_W, 107: payload width. The EX/MEM packing is 107 bits.
- CTRL_W, 5: low payload bits [CTRL_W-1:0] that hold control (WB/MEM). Range 1..DATA_W.
- SKID, 0: 0 selects a single register with combinational in_ready. 1 selects main plus skid register with registered in_ready.
- CNT_W, 16: stall counter width.

Ports:
- clock, in, 1: single clock, rising edge.
- reset, in, 1: synchronous, active-high.
- in_valid, in, 1: upstream beat present.
- in_ready, out, 1: stage can accept a beat this cycle.
- in_data, in, DATA_W: upstream payload.
- flush, in, 1: synchronous kill of all held beats (branch taken / exception).
- out_valid, out, 1: downstream beat present.
- out_ready, in, 1: downstream accepts this cycle.
- out_data, out, DATA_W: payload. The control field reads 0 whenever out_valid=0.
- stall_cnt, out, CNT_W: saturating count of cycles with out_valid && !out_ready.

## Operation

- Transfer in: in_valid && in_ready. Transfer out: out_valid && out_ready.
- SKID=0:
  - in_ready = !out_valid || out_ready (combinational).
  - On transfer in, the main register loads in_data and out_valid=1.
  - On transfer out with no transfer in, out_valid=0.
- SKID=1:
  - in_ready = !skid_valid, driven from a flop.
  - Transfer in while main is full and !out_ready: the beat goes to the skid register.
  - Transfer out while skid is full: skid moves to main, and a simultaneous new beat goes to skid.
  - Order is strictly FIFO.
- Bubble:
  - out_data[CTRL_W-1:0] = 0 when out_valid=0. This is a forced NOP for the WB/MEM control.
  - Non-control bits hold their last value.
- flush:
  - Priority: below reset, above everything else.
  - Next cycle: all valid bits = 0.
  - A beat presented during the flush cycle is dropped. in_ready is still computed normally, so upstream sees the beat as consumed.
- Stall counter:
  - Increments each cycle with out_valid && !out_ready.
  - Saturates at all-ones.
  - Cleared only by reset; flush does not clear it.

## Timing

- Reset values: out_valid=0, out_data=0, stall_cnt=0, skid empty.
  - in_ready in the cycle after reset: 1 for both SKID settings.
- Latency: 1 cycle from transfer in to out_valid.
- Throughput: 1 beat per cycle in both modes with out_ready held high.
- SKID=0: no path from out_ready to in_ready is registered.
- SKID=1: no combinational path from out_ready to in_ready.
  - Capacity is 2 beats.
  - in_ready drops the cycle after the skid fills and rises the cycle after the skid drains.
- Simultaneous transfer in and out with SKID=0 and main full: main reloads and out_valid stays 1.
- Reset asserted mid-stream: all held beats are lost, and reset values appear on the next edge.
- flush together with out_ready: a transfer out on that edge still completes downstream. Its source is cleared afterwards.

## Structure

- Shared package pipe_pkg:
  - Field widths WB_W=2, MEM_W=3, CTRL_W=WB_W+MEM_W, REG_ADDR_W=5, XLEN=32.
  - EXMEM_W=107.
  - Packing offsets for the EX/MEM fields: ctrl at LSB, then dst reg, zero, read data 2, ALU result, PC+4.
- Sub-module pipe_skid_slot is a single valid+data holding register. It is instantiated once for main, and a second time under generate when SKID=1.
- Stall counter and bubble masking stay in the top level.

## Test plan

- **Reset:** reset=1 for 2 cycles with in_valid=1 and in_data=0x5A.. → out_valid=0, out_data=0, stall_cnt=0. in_ready=1 on the first cycle after reset.
- **Streaming:** SKID=0 and 1, out_ready=1, in_data=1,2,3… each cycle → out_data shows the same sequence one cycle later, with no gaps.
- **Backpressure:**
  - SKID=1: beats A,B,C offered while out_ready=0 → A in main, B in skid, in_ready=0, C held upstream.
  - Then out_ready=1 → A, B, C are delivered in order on consecutive cycles.
  - stall_cnt equals the count of stalled cycles.
- **Flush:** flush=1 while 2 beats are held and in_valid=1 with D → next cycle out_valid=0 and out_data[4:0]=0. D never appears.
- **Bubble masking:** in_data ctrl=5'b10111, transfer out, no new beat → out_valid=0, out_data[4:0]=0, upper bits unchanged.
- **Saturation:** CNT_W=4, out_valid=1 and out_ready=0 for 20 cycles → stall_cnt=15 and holds there.
